// File: rtl/tiger_round.sv
// tiger_round: sequential Tiger round step engine.
// Reads the four registered Tiger S-box ROMs (tables A-D) over two lookup
// cycles and returns the updated a, b, c for one round per start.
// The multiply by 5/7/9 is done by shift-add only.
// Optional macro TIGER_ROUND_MUL_PIPE_EN splits the final multiply into a
// shift stage (MUL) and an add/subtract stage (MUL2). This adds one cycle
// of latency. The results are the same with or without the macro.
module tiger_round (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_ready,
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic [63:0] i_c,
  input  logic [63:0] i_x,
  input  logic [1:0]  i_mul,
  output logic [63:0] o_a,
  output logic [63:0] o_b,
  output logic [63:0] o_c,
  output logic        o_done,
  output logic [7:0]  o_sa_addr,
  output logic [7:0]  o_sb_addr,
  output logic [7:0]  o_sc_addr,
  output logic [7:0]  o_sd_addr,
  input  logic [63:0] i_sa_data,
  input  logic [63:0] i_sb_data,
  input  logic [63:0] i_sc_data,
  input  logic [63:0] i_sd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LK0,
    S_LK1,
    S_ACC,
    S_MUL,
    S_MUL2,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] a_q, b_q, c_q;      // latched a, b and c' = c ^ x
  logic [1:0]  mul_q;              // 0 -> x5, 1 -> x7, 2/3 -> x9
  logic [63:0] ap_q;               // a' once the even lookups return
  logic [63:0] sum_q;              // b + odd-lookup XOR
  logic [63:0] oa_q, ob_q, oc_q;
  logic        accept;
  logic [63:0] even_xor, odd_xor;
  logic [63:0] shl, prod;
  logic        mul_sub;

  assign o_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign o_done  = (state_q == S_DONE);
  assign accept  = i_start && o_ready;

  // The even lookup data arrives in LK1. The odd lookup data arrives in ACC.
  assign even_xor = i_sa_data ^ i_sb_data ^ i_sc_data ^ i_sd_data;
  assign odd_xor  = i_sd_data ^ i_sc_data ^ i_sb_data ^ i_sa_data;

  // Shift-add multiply. x5 = (s<<2)+s, x7 = (s<<3)-s, x9 = (s<<3)+s.
  assign mul_sub = (mul_q == 2'd1);
  assign shl     = (mul_q == 2'd0) ? (sum_q << 2) : (sum_q << 3);
  assign prod    = mul_sub ? (shl - sum_q) : (shl + sum_q);

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; starts while busy are dropped, not queued
  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_LK0;
      S_LK0:  state_d = S_LK1;
      S_LK1:  state_d = S_ACC;
      S_ACC:  state_d = S_MUL;
`ifdef TIGER_ROUND_MUL_PIPE_EN
      S_MUL:  state_d = S_MUL2;
      S_MUL2: state_d = S_DONE;
`else
      S_MUL:  state_d = S_DONE;
`endif
      S_DONE: state_d = i_start ? S_LK0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // S-box addresses decoded from the registered state and c' only
  always_comb begin
    o_sa_addr = 8'h00;
    o_sb_addr = 8'h00;
    o_sc_addr = 8'h00;
    o_sd_addr = 8'h00;
    if (state_q == S_LK0) begin
      o_sa_addr = c_q[7:0];
      o_sb_addr = c_q[23:16];
      o_sc_addr = c_q[39:32];
      o_sd_addr = c_q[55:48];
    end else if (state_q == S_LK1) begin
      o_sd_addr = c_q[15:8];
      o_sc_addr = c_q[31:24];
      o_sb_addr = c_q[47:40];
      o_sa_addr = c_q[63:56];
    end
  end

  // Round datapath: latch inputs, fold lookup data, accumulate
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      mul_q <= '0;
      ap_q  <= '0;
      sum_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= i_a;
        b_q   <= i_b;
        c_q   <= i_c ^ i_x;
        mul_q <= i_mul;
      end
      if (state_q == S_LK1) ap_q  <= a_q - even_xor;
      if (state_q == S_ACC) sum_q <= b_q + odd_xor;
    end
  end

`ifdef TIGER_ROUND_MUL_PIPE_EN
  logic [63:0] term_q, addend_q;
  logic        sub_q;

  // MUL stage: register the shifted term and the addend
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      term_q   <= '0;
      addend_q <= '0;
      sub_q    <= 1'b0;
    end else if (state_q == S_MUL) begin
      term_q   <= shl;
      addend_q <= sum_q;
      sub_q    <= mul_sub;
    end
  end

  // MUL2 stage: final add/subtract and load all results together
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      oa_q <= '0;
      ob_q <= '0;
      oc_q <= '0;
    end else if (state_q == S_MUL2) begin
      ob_q <= sub_q ? (term_q - addend_q) : (term_q + addend_q);
      oa_q <= ap_q;
      oc_q <= c_q;
    end
  end
`else
  // MUL stage: complete the multiply and load all results together
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      oa_q <= '0;
      ob_q <= '0;
      oc_q <= '0;
    end else if (state_q == S_MUL) begin
      ob_q <= prod;
      oa_q <= ap_q;
      oc_q <= c_q;
    end
  end
`endif

  assign o_a = oa_q;
  assign o_b = ob_q;
  assign o_c = oc_q;

endmodule
